// File: rtl/seg7_reader.sv
// -----------------------------------------------------------------------------
// seg7_reader
//
// Receiving end of a hex-to-seven-segment display link. The seven active-high
// segment lines are sampled every cycle. Once a pattern has held steady for
// STABLE_CYCLES consecutive samples, it is reported exactly once:
//   - a legal hex glyph updates digit_o and pulses valid_o for one cycle
//   - the all-dark pattern (7'h00) raises blank_o without any pulse
//   - anything else pulses err_o and bumps a saturating error counter
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples needed before a report (2..255)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   a..g       in   segment lines; sampled vector is {a,b,c,d,e,f,g}, a = MSB
//   digit_o    out  [3:0] last legal digit reported, held between reports
//   valid_o    out  one-cycle pulse on a legal report
//   err_o      out  one-cycle pulse on an illegal, non-blank report
//   blank_o    out  high while the last reported stable pattern is blank
//   err_cnt_o  out  [7:0] number of err_o pulses, saturating at 255
// -----------------------------------------------------------------------------
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] digit_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       blank_o,
    output logic [7:0] err_cnt_o
);

    // Counter value at which the candidate is considered stable. The counter
    // holds 1 on the first comparison edge, so the report lands STABLE_CYCLES
    // edges after the pattern was first captured into s_q.
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_param
        $error("seg7_reader: STABLE_CYCLES must be within 2..255");
    end

    typedef enum logic {
        ST_HOLD   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Maps a segment vector to {legal, code}. Blank and illegal patterns both
    // come back with legal = 0; the caller tells them apart.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h7E:   res = {1'b1, 4'h0};
            7'h30:   res = {1'b1, 4'h1};
            7'h6D:   res = {1'b1, 4'h2};
            7'h79:   res = {1'b1, 4'h3};
            7'h33:   res = {1'b1, 4'h4};
            7'h5B:   res = {1'b1, 4'h5};
            7'h5F:   res = {1'b1, 4'h6};
            7'h70:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h7B:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h1F:   res = {1'b1, 4'hB};
            7'h4E:   res = {1'b1, 4'hC};
            7'h3D:   res = {1'b1, 4'hD};
            7'h4F:   res = {1'b1, 4'hE};
            7'h47:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Input sample stage
    logic [6:0] s_q, s_d;

    // Stability tracker
    state_t     state_q, state_d;
    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;

    // Registered outputs
    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       blank_q, blank_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       report;
    logic [4:0] dec;

    assign dec = decode_seg(cand_q);

    always_comb begin
        s_d       = {a, b, c, d, e, f, g};
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        report    = 1'b0;

        case (state_q)
            ST_HOLD: begin
                // Any change, even back to an earlier pattern, starts a new
                // stability window.
                if (s_q != cand_q) begin
                    cand_d  = s_q;
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (s_q != cand_q) begin
                    cand_d = s_q;
                    cnt_d  = 8'd1;
                end else if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    report  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Report decode: pulses default low so each report lasts one cycle.
    always_comb begin
        digit_d   = digit_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        blank_d   = blank_q;
        err_cnt_d = err_cnt_q;

        if (report) begin
            if (dec[4]) begin
                digit_d = dec[3:0];
                valid_d = 1'b1;
                blank_d = 1'b0;
            end else if (cand_q == 7'h00) begin
                blank_d = 1'b1;
            end else begin
                err_d     = 1'b1;
                blank_d   = 1'b0;
                err_cnt_d = sat_inc8(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= 7'h00;
            state_q   <= ST_HOLD;
            cand_q    <= 7'h00;
            cnt_q     <= 8'd0;
            digit_q   <= 4'h0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            blank_q   <= 1'b1;
            err_cnt_q <= 8'd0;
        end else begin
            s_q       <= s_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            blank_q   <= blank_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign digit_o   = digit_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign blank_o   = blank_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// -----------------------------------------------------------------------------
// tb_seg7_reader
//
// Directed bench for seg7_reader with the default STABLE_CYCLES of 4. Inputs
// change on falling edges; outputs are sampled on falling edges. A monitor
// keeps running totals of valid_o / err_o pulses so each step can compare
// pulse counts over its own window.
// -----------------------------------------------------------------------------
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a, b, c, d, e, f, g;
    logic [3:0] digit_o;
    logic       valid_o;
    logic       err_o;
    logic       blank_o;
    logic [7:0] err_cnt_o;

    logic [6:0] pat = 7'h00;
    assign {a, b, c, d, e, f, g} = pat;

    int tests = 0;
    int fails = 0;
    int vtot  = 0;
    int etot  = 0;
    int both  = 0;

    logic [6:0] seg_tab [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .digit_o   (digit_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .blank_o   (blank_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o) vtot = vtot + 1;
            if (err_o) etot = etot + 1;
            if (valid_o && err_o) both = both + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive pattern p at the current falling edge and hold it for n cycles.
    task automatic hold(input logic [6:0] p, input int n);
        pat = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_digit"},   32'(digit_o),   32'h0);
        chk({tag, "_valid"},   32'(valid_o),   32'h0);
        chk({tag, "_err"},     32'(err_o),     32'h0);
        chk({tag, "_blank"},   32'(blank_o),   32'h1);
        chk({tag, "_err_cnt"}, 32'(err_cnt_o), 32'h0);
    endtask

    initial begin
        int v0;
        int e0;
        logic alt;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;

        // All-zero input after reset must stay silent
        hold(7'h00, 6);
        chk("idle_valid_cnt", 32'(vtot), 32'd0);
        chk("idle_err_cnt",   32'(etot), 32'd0);
        chk("idle_blank",     32'(blank_o), 32'h1);

        // Sweep of all 16 glyphs: pulse on the 5th falling edge after the change
        v0 = vtot;
        for (int i = 0; i < 16; i++) begin
            pat = seg_tab[i];
            for (int j = 1; j <= 6; j++) begin
                @(negedge clk);
                chk("sweep_valid", 32'(valid_o), (j == 5) ? 32'h1 : 32'h0);
                chk("sweep_err",   32'(err_o),   32'h0);
                if (j == 5) chk("sweep_digit", 32'(digit_o), 32'(i));
                if (i == 0 && j == 4) chk("sweep_blank_pre", 32'(blank_o), 32'h1);
                if (i == 0 && j == 5) chk("sweep_blank_post", 32'(blank_o), 32'h0);
            end
        end
        chk("sweep_pulses", 32'(vtot - v0), 32'd16);
        chk("sweep_errs",   32'(etot),      32'd0);

        // Glitch filter: short 7E never reported
        v0 = vtot;
        hold(7'h7E, 2);
        hold(7'h30, 8);
        chk("glitch1_pulses", 32'(vtot - v0), 32'd1);
        chk("glitch1_digit",  32'(digit_o),   32'h1);
        // One-sample 7E inside a stable 30: only the return to 30 is reported
        v0 = vtot;
        hold(7'h7E, 1);
        hold(7'h30, 8);
        chk("glitch2_pulses", 32'(vtot - v0), 32'd1);
        chk("glitch2_digit",  32'(digit_o),   32'h1);
        chk("glitch2_errs",   32'(etot),      32'd0);

        // Illegal then blank
        v0 = vtot;
        e0 = etot;
        hold(7'h01, 8);
        chk("illegal_errs",    32'(etot - e0),  32'd1);
        chk("illegal_err_cnt", 32'(err_cnt_o),  32'd1);
        chk("illegal_digit",   32'(digit_o),    32'h1);
        chk("illegal_blank",   32'(blank_o),    32'h0);
        chk("illegal_valids",  32'(vtot - v0),  32'd0);
        hold(7'h00, 8);
        chk("blank_level",  32'(blank_o),   32'h1);
        chk("blank_errs",   32'(etot - e0), 32'd1);
        chk("blank_valids", 32'(vtot - v0), 32'd0);
        chk("blank_digit",  32'(digit_o),   32'h1);

        // Repeat suppression
        v0 = vtot;
        hold(7'h6D, 20);
        chk("repeat_pulses", 32'(vtot - v0), 32'd1);
        chk("repeat_digit",  32'(digit_o),   32'h2);
        chk("repeat_blank",  32'(blank_o),   32'h0);
        hold(7'h00, 6);
        chk("repeat_gap_blank", 32'(blank_o), 32'h1);
        hold(7'h6D, 6);
        chk("repeat_again_pulses", 32'(vtot - v0), 32'd2);
        chk("repeat_again_digit",  32'(digit_o),   32'h2);

        // Error counter saturation (starts at 1)
        v0  = vtot;
        e0  = etot;
        alt = 1'b0;
        for (int r = 0; r < 255; r++) begin
            hold(alt ? 7'h02 : 7'h01, 6);
            alt = ~alt;
        end
        chk("sat_errs",    32'(etot - e0),  32'd255);
        chk("sat_err_cnt", 32'(err_cnt_o),  32'd255);
        e0 = etot;
        for (int r = 0; r < 5; r++) begin
            hold(alt ? 7'h02 : 7'h01, 6);
            alt = ~alt;
        end
        chk("sat_more_errs",    32'(etot - e0), 32'd5);
        chk("sat_more_err_cnt", 32'(err_cnt_o), 32'd255);
        chk("sat_valids",       32'(vtot - v0), 32'd0);
        chk("sat_digit",        32'(digit_o),   32'h2);

        // Reset two cycles into SETTLE of 79
        pat = 7'h79;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outs("rst_settle");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("rst_settle_valid", 32'(valid_o), (j == 5) ? 32'h1 : 32'h0);
            if (j == 5) chk("rst_settle_digit", 32'(digit_o), 32'h3);
        end

        // Reset while valid_o is high
        #1 rst = 1'b1;
        #1 chk_reset_outs("rst_pulse");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk("rst_pulse_valid", 32'(valid_o), (j == 5) ? 32'h1 : 32'h0);
            if (j == 5) chk("rst_pulse_digit", 32'(digit_o), 32'h3);
        end

        chk("never_both", 32'(both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
